float_add_ctrl: RTL and testbench

- Sequencing controller for the fraction-add datapath (`float_add`). The datapath takes `dp_a`/`dp_b` fractions, mux selects and a right-shift amount, and returns a 25-bit sum.
- This block accepts two IEEE-754 single-precision operands over a valid/ready handshake. It unpacks them, compares exponents, and drives the datapath selects and shift.
- It registers the sum, normalizes it, packs the result and returns it over a second valid/ready handshake.
- Scope is same-sign normal operands only. Everything else is flagged as unsupported.

---
 rtl/float_add_pkg.sv | 31 +++
 rtl/float_add_norm.sv | 64 ++++++
 rtl/float_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_float_add_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/float_add_pkg.sv
// Shared types and constants for the single-precision add controller.
package float_add_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_fields_t;

    // Zero (denormal/zero) and all-ones (inf/NaN) exponents are outside the
    // normal-operand scope of this controller.
    function automatic logic is_special_exp(input logic [EXP_W-1:0] e);
        return (e == '0) || (e == '1);
    endfunction

endpackage

// File: rtl/float_add_norm.sv
// Combinational normalize/pack stage for the fraction-add result.
// Optional macro FLOAT_ADD_ROUND_EN: round the dropped bit half-to-even
// when the sum carried out; otherwise the dropped bit is truncated.
module float_add_norm
    import float_add_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W+1:0]       sum_i,
    input  logic [EXP_W-1:0]        e_big_i,
    input  logic                    sign_i,
    output logic [EXP_W+FRAC_W:0]   result_o,
    output logic                    ovf_o
);

    logic [FRAC_W-1:0] mant;
    logic [EXP_W:0]    e;

`ifdef FLOAT_ADD_ROUND_EN
    logic [FRAC_W:0]   mant_rnd;
`else
    logic              unused_drop_bit;
    assign unused_drop_bit = sum_i[0];
`endif

    // Pick the mantissa window from the carry bit, then pack or saturate to infinity.
    always_comb begin
        mant     = '0;
        e        = '0;
        result_o = '0;
        ovf_o    = 1'b0;
`ifdef FLOAT_ADD_ROUND_EN
        mant_rnd = '0;
`endif
        if (sum_i[FRAC_W+1]) begin
            mant = sum_i[FRAC_W:1];
            e    = {1'b0, e_big_i} + (EXP_W+1)'(1);
`ifdef FLOAT_ADD_ROUND_EN
            // Only one bit is dropped, so a set dropped bit is always an exact
            // tie: round up only when that makes the mantissa even.
            if (sum_i[0] && mant[0]) begin
                mant_rnd = {1'b0, mant} + (FRAC_W+1)'(1);
                mant     = mant_rnd[FRAC_W-1:0];
                if (mant_rnd[FRAC_W]) begin
                    e = e + (EXP_W+1)'(1);
                end
            end
`endif
        end else begin
            mant = sum_i[FRAC_W-1:0];
            e    = {1'b0, e_big_i};
        end

        // Overflow is judged after any rounding carry.
        if (e >= (EXP_W+1)'(EXP_MAX)) begin
            ovf_o    = 1'b1;
            result_o = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            result_o = {sign_i, e[EXP_W-1:0], mant};
        end
    end

endmodule

// File: rtl/float_add_ctrl.sv
// Sequencing controller for the external fraction-add datapath.
// Accepts two same-sign normal singles, aligns them, captures the datapath
// sum, normalizes and returns the packed result. Optional macro
// FLOAT_ADD_ROUND_EN enables half-to-even rounding in the normalize stage.
module float_add_ctrl
    import float_add_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   op_a,
    input  logic [EXP_W+FRAC_W:0]   op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    ovf,
    output logic                    unsup,
    output logic [FRAC_W-1:0]       dp_a,
    output logic [FRAC_W-1:0]       dp_b,
    output logic [EXP_W-1:0]        dp_shift,
    output logic                    dp_sel_a,
    output logic                    dp_sel_b,
    input  logic [FRAC_W+1:0]       dp_sum
);

    state_t                  state_q;
    logic [EXP_W+FRAC_W:0]   op_a_q;
    logic [EXP_W+FRAC_W:0]   op_b_q;
    logic [FRAC_W+1:0]       sum_q;
    logic [EXP_W-1:0]        e_big_q;
    logic                    sign_q;

    fp_fields_t              fa;
    fp_fields_t              fb;
    logic                    unsup_d;
    logic                    a_ge_b;
    logic [EXP_W+FRAC_W:0]   norm_result;
    logic                    norm_ovf;

    assign fa      = op_a_q;
    assign fb      = op_b_q;
    assign unsup_d = is_special_exp(fa.exp) || is_special_exp(fb.exp) || (fa.sign != fb.sign);
    assign a_ge_b  = (fa.exp >= fb.exp);

    float_add_norm #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_norm (
        .sum_i    (sum_q),
        .e_big_i  (e_big_q),
        .sign_i   (sign_q),
        .result_o (norm_result),
        .ovf_o    (norm_ovf)
    );

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            unsup     <= 1'b0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_shift  <= '0;
            dp_sel_a  <= 1'b0;
            dp_sel_b  <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sum_q     <= '0;
            e_big_q   <= '0;
            sign_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a_q   <= op_a;
                        op_b_q   <= op_b;
                        in_ready <= 1'b0;
                        state_q  <= ALIGN;
                    end
                end
                ALIGN: begin
                    dp_a   <= fa.frac;
                    dp_b   <= fb.frac;
                    sign_q <= fa.sign;
                    if (unsup_d) begin
                        unsup     <= 1'b1;
                        result    <= QNAN;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        // Larger exponent goes unshifted; the smaller is shifted right.
                        if (a_ge_b) begin
                            dp_sel_a <= 1'b0;
                            dp_sel_b <= 1'b1;
                            dp_shift <= fa.exp - fb.exp;
                            e_big_q  <= fa.exp;
                        end else begin
                            dp_sel_a <= 1'b1;
                            dp_sel_b <= 1'b0;
                            dp_shift <= fb.exp - fa.exp;
                            e_big_q  <= fb.exp;
                        end
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= dp_sum;
                    state_q <= NORM;
                end
                NORM: begin
                    result    <= norm_result;
                    ovf       <= norm_ovf;
                    out_valid <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ovf       <= 1'b0;
                        unsup     <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_add_ctrl.sv
// Directed bench for float_add_ctrl with a behavioural model of the
// fraction-add datapath driven from the controller's dp_* outputs.
module tb_float_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        ovf;
    logic        unsup;
    logic [22:0] dp_a;
    logic [22:0] dp_b;
    logic [7:0]  dp_shift;
    logic        dp_sel_a;
    logic        dp_sel_b;
    logic [24:0] dp_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Datapath model: hidden bit restored, smaller operand shifted right.
    logic [23:0] big_m;
    logic [23:0] sml_m;
    assign big_m  = dp_sel_a ? {1'b1, dp_b} : {1'b1, dp_a};
    assign sml_m  = (dp_sel_b ? {1'b1, dp_b} : {1'b1, dp_a}) >> dp_shift;
    assign dp_sum = {1'b0, big_m} + {1'b0, sml_m};

    float_add_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unsup     (unsup),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_shift  (dp_shift),
        .dp_sel_a  (dp_sel_a),
        .dp_sel_b  (dp_sel_b),
        .dp_sum    (dp_sum)
    );

`ifdef FLOAT_ADD_ROUND_EN
    localparam logic [31:0] RND_ODD = 32'h4000_0002;
`else
    localparam logic [31:0] RND_ODD = 32'h4000_0001;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        unsup;
        int          lat;
        logic [7:0]  shift;
        logic        sel_a;
        logic [24:0] sum;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one operand pair, watch latency and datapath controls, check the result.
    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        logic [7:0]  sh;
        logic        sa;
        logic        sb;
        logic [24:0] sm;
        lat = 0;
        sh  = '0;
        sa  = 1'b0;
        sb  = 1'b0;
        sm  = '0;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        op_a     = v.a;
        op_b     = v.b;
        in_valid = 1'b1;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            if (c == 2) begin
                sh = dp_shift;
                sa = dp_sel_a;
                sb = dp_sel_b;
                sm = dp_sum;
            end
            if (out_valid) lat = c;
        end
        chk("latency", 32'(lat), 32'(v.lat));
        chk("result", result, v.res);
        chk("ovf", 32'(ovf), 32'(v.ovf));
        chk("unsup", 32'(unsup), 32'(v.unsup));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (!v.unsup) begin
            chk("dp_shift", 32'(sh), 32'(v.shift));
            chk("dp_sel_a", 32'(sa), 32'(v.sel_a));
            chk("dp_sel_b", 32'(sb), 32'(!v.sel_a));
            chk("dp_sum", 32'(sm), 32'(v.sum));
        end
        $display("vec %0d: a=%h b=%h result=%h ovf=%0b unsup=%0b lat=%0d",
                 idx, v.a, v.b, result, ovf, unsup, lat);
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_clr", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
        chk("ovf_clr", 32'(ovf), 32'd0);
        chk("unsup_clr", 32'(unsup), 32'd0);
    endtask

    initial begin
        //          a             b             res           ovf   unsup lat sh     sel_a sum
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4, 8'd0,  1'b0, 25'h1000000};
        vecs[1]  = '{32'h3FC00000, 32'h3E800000, 32'h3FE00000, 1'b0, 1'b0, 4, 8'd2,  1'b0, 25'h0E00000};
        vecs[2]  = '{32'h3E800000, 32'h3FC00000, 32'h3FE00000, 1'b0, 1'b0, 4, 8'd2,  1'b1, 25'h0E00000};
        vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 4, 8'd0,  1'b0, 25'h1FFFFFE};
        vecs[4]  = '{32'h3F800000, 32'hBF800000, 32'h7FC00000, 1'b0, 1'b1, 2, 8'd0,  1'b0, 25'h0};
        vecs[5]  = '{32'h00000001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 2, 8'd0,  1'b0, 25'h0};
        vecs[6]  = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 2, 8'd0,  1'b0, 25'h0};
        vecs[7]  = '{32'h3F800003, 32'h3F800000, RND_ODD,      1'b0, 1'b0, 4, 8'd0,  1'b0, 25'h1000003};
        vecs[8]  = '{32'h3F800001, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4, 8'd0,  1'b0, 25'h1000001};
        vecs[9]  = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0, 1'b0, 4, 8'd24, 1'b0, 25'h0800000};
        vecs[10] = '{32'h3F800000, 32'h3F000000, 32'h3FC00000, 1'b0, 1'b0, 4, 8'd1,  1'b0, 25'h0C00000};
        vecs[11] = '{32'hBF800000, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0, 4, 8'd0,  1'b0, 25'h1000000};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unsup", 32'(unsup), 32'd0);
        chk("rst_dp_a", 32'(dp_a), 32'd0);
        chk("rst_dp_b", 32'(dp_b), 32'd0);
        chk("rst_dp_shift", 32'(dp_shift), 32'd0);
        chk("rst_dp_sel", {30'd0, dp_sel_a, dp_sel_b}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: result must be held while out_ready stays low.
        begin
            int seen;
            seen = 0;
            out_ready = 1'b0;
            @(negedge clk);
            op_a     = 32'h3FC00000;
            op_b     = 32'h3E800000;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            for (int c = 0; c < 10 && seen == 0; c++) begin
                @(negedge clk);
                if (out_valid) seen = 1;
            end
            chk("bp_out_valid_seen", 32'(seen), 32'd1);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_result", result, 32'h3FE00000);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
            end
            $display("backpressure: result=%h held for 10 cycles", result);
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_release", 32'(out_valid), 32'd0);
            chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        end

        // Reset during ADD discards the pending operation.
        begin
            int spurious;
            spurious = 0;
            @(negedge clk);
            op_a     = 32'h3F800000;
            op_b     = 32'h3F800000;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
            rst_n = 1'b0;
            #1;
            chk("midrst_out_valid", 32'(out_valid), 32'd0);
            chk("midrst_in_ready", 32'(in_ready), 32'd1);
            chk("midrst_dp_shift", 32'(dp_shift), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (out_valid) spurious++;
            end
            chk("midrst_no_result", 32'(spurious), 32'd0);
            $display("reset in ADD: in_ready=%0b out_valid=%0b", in_ready, out_valid);
            run_vec(vecs[1], 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
